// File: rtl/road_scroll_ctrl.sv
// Road line sequencer: turns per-frame speed into paced need_new_line pulses and steps levels.
// Optional build macro ROAD_SCROLL_LEVEL_WAIT_EN: LEVEL_DONE waits for start_game instead of a frame hold.
module road_scroll_ctrl #(
  parameter int unsigned LEVEL_LINES       = 1920,
  parameter int unsigned FRAC_W            = 4,
  parameter int unsigned MAX_LEVEL         = 1,
  parameter int unsigned LINE_GAP          = 4,
  parameter int unsigned LEVEL_HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_game,
  input  logic        pause,
  input  logic [7:0]  speed,
  output logic        need_new_line,
  output logic [2:0]  level,
  output logic [11:0] line_count,
  output logic        level_done,
  output logic        game_done
);

  localparam int unsigned GAP_W    = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int unsigned PEND_W   = 6;
  localparam int unsigned PEND_MAX = 63;
  localparam int unsigned SUM_W    = 9;
  localparam int unsigned LINE_W   = 12;
  localparam int unsigned LVL_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LEVEL_DONE,
    S_GAME_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                nnl_q, nnl_d;
  logic                done_q, done_d;
  logic                game_q, game_d;
`ifndef ROAD_SCROLL_LEVEL_WAIT_EN
  localparam int unsigned HOLD_W = (LEVEL_HOLD_FRAMES > 1) ? $clog2(LEVEL_HOLD_FRAMES + 1) : 1;
  logic [HOLD_W-1:0]   hold_q, hold_d;
`endif

  logic                frame_c;
  logic                pulse_c;
  logic [SUM_W-1:0]    sum_c;
  logic [SUM_W-1:0]    owed_c;
  logic [SUM_W:0]      pend_sum_c;
  logic [PEND_W-1:0]   pend_sat_c;

  // Frame accounting and pulse eligibility
  always_comb begin
    frame_c    = startOfFrame && !pause;
    pulse_c    = (state_q == S_RUN) && (pending_q != '0) && !pause && (gap_q == '0);
    sum_c      = SUM_W'(acc_q) + SUM_W'(speed);
    owed_c     = frame_c ? (sum_c >> FRAC_W) : '0;
    pend_sum_c = (SUM_W + 1)'(pending_q) + (SUM_W + 1)'(owed_c) - (SUM_W + 1)'(pulse_c);
    pend_sat_c = (pend_sum_c > (SUM_W + 1)'(PEND_MAX)) ? PEND_W'(PEND_MAX) : pend_sum_c[PEND_W-1:0];
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pending_d = pending_q;
    gap_d     = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
    line_d    = line_q;
    level_d   = level_q;
    nnl_d     = 1'b0;
    done_d    = 1'b0;
`ifndef ROAD_SCROLL_LEVEL_WAIT_EN
    hold_d    = hold_q;
`endif

    unique case (state_q)
      S_IDLE, S_GAME_DONE: begin
        if (start_game) begin
          state_d   = S_RUN;
          level_d   = LVL_W'(1);
          acc_d     = '0;
          pending_d = '0;
          line_d    = '0;
          gap_d     = '0;
        end
      end

      S_RUN: begin
        if (frame_c) acc_d = sum_c[FRAC_W-1:0];
        pending_d = pend_sat_c;
        if (pulse_c) begin
          nnl_d  = 1'b1;
          line_d = line_q + LINE_W'(1);
          gap_d  = GAP_W'(LINE_GAP - 1);
          // Last line of the level: drop any remaining debt and stop issuing
          if (line_q == LINE_W'(LEVEL_LINES - 1)) begin
            done_d    = 1'b1;
            pending_d = '0;
            acc_d     = '0;
`ifndef ROAD_SCROLL_LEVEL_WAIT_EN
            hold_d    = '0;
`endif
            state_d   = (level_q == LVL_W'(MAX_LEVEL)) ? S_GAME_DONE : S_LEVEL_DONE;
          end
        end
      end

      S_LEVEL_DONE: begin
`ifdef ROAD_SCROLL_LEVEL_WAIT_EN
        if (start_game) begin
`else
        if (startOfFrame) hold_d = hold_q + HOLD_W'(1);
        if (startOfFrame && (hold_q == HOLD_W'(LEVEL_HOLD_FRAMES - 1))) begin
`endif
          state_d   = S_RUN;
          level_d   = level_q + LVL_W'(1);
          line_d    = '0;
          acc_d     = '0;
          pending_d = '0;
          gap_d     = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    game_d = (state_d == S_GAME_DONE);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      pending_q <= '0;
      gap_q     <= '0;
      line_q    <= '0;
      level_q   <= '0;
      nnl_q     <= 1'b0;
      done_q    <= 1'b0;
      game_q    <= 1'b0;
`ifndef ROAD_SCROLL_LEVEL_WAIT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pending_q <= pending_d;
      gap_q     <= gap_d;
      line_q    <= line_d;
      level_q   <= level_d;
      nnl_q     <= nnl_d;
      done_q    <= done_d;
      game_q    <= game_d;
`ifndef ROAD_SCROLL_LEVEL_WAIT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign need_new_line = nnl_q;
  assign level         = level_q;
  assign line_count    = line_q;
  assign level_done    = done_q;
  assign game_done     = game_q;

endmodule

// File: tb/tb_road_scroll_ctrl.sv
// Bench for road_scroll_ctrl: directed scenarios plus randomized traffic against a line-debt model.
module tb_road_scroll_ctrl;

  localparam int LL   = 8;
  localparam int FW   = 4;
  localparam int ML   = 2;
  localparam int GAP  = 4;
  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        start_game = 1'b0;
  logic        pause = 1'b0;
  logic [7:0]  speed = 8'h00;
  logic        need_new_line;
  logic [2:0]  level;
  logic [11:0] line_count;
  logic        level_done;
  logic        game_done;

  int checks = 0;
  int errors = 0;

  road_scroll_ctrl #(
    .LEVEL_LINES(LL), .FRAC_W(FW), .MAX_LEVEL(ML), .LINE_GAP(GAP), .LEVEL_HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
    .pause(pause), .speed(speed), .need_new_line(need_new_line), .level(level),
    .line_count(line_count), .level_done(level_done), .game_done(game_done)
  );

  always #5 clk = ~clk;

  // Reference model: stage 0 idle, 1 run, 2 level done, 3 game done; time-based pulse spacing
  int m_stage = 0, m_level = 0, m_cnt = 0, m_acc = 0, m_pend = 0, m_hold = 0;
  int m_last = -1000, m_t = 0;
  bit m_nnl = 0, m_ld = 0;

  function automatic void m_begin_level(input int lvl);
    m_level = lvl; m_cnt = 0; m_acc = 0; m_pend = 0; m_last = -1000; m_stage = 1;
  endfunction

  function automatic void model_edge(input bit r, input bit sof, input bit sg, input bit pz, input int spd);
    bit pulse;
    int owed;
    m_t++;
    m_nnl = 0;
    m_ld  = 0;
    if (r) begin
      m_stage = 0; m_level = 0; m_cnt = 0; m_acc = 0; m_pend = 0; m_hold = 0; m_last = -1000;
      return;
    end
    case (m_stage)
      0, 3: if (sg) m_begin_level(1);
      1: begin
        pulse = (m_pend > 0) && !pz && (m_t - m_last >= GAP);
        owed  = 0;
        if (sof && !pz) begin
          owed  = (m_acc + spd) / (1 << FW);
          m_acc = (m_acc + spd) % (1 << FW);
        end
        m_pend = m_pend + owed - (pulse ? 1 : 0);
        if (m_pend > 63) m_pend = 63;
        if (pulse) begin
          m_nnl = 1; m_cnt++; m_last = m_t;
          if (m_cnt == LL) begin
            m_ld = 1; m_pend = 0; m_acc = 0; m_hold = 0;
            m_stage = (m_level == ML) ? 3 : 2;
          end
        end
      end
      2: begin
`ifdef ROAD_SCROLL_LEVEL_WAIT_EN
        if (sg) m_begin_level(m_level + 1);
`else
        if (sof) begin
          m_hold++;
          if (m_hold == HOLD) m_begin_level(m_level + 1);
        end
`endif
      end
      default: ;
    endcase
  endfunction

  task automatic tick(input bit r, input bit sof, input bit sg, input bit pz, input logic [7:0] spd);
    @(negedge clk);
    resetN = r; startOfFrame = sof; start_game = sg; pause = pz; speed = spd;
    model_edge(r, sof, sg, pz, int'(spd));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int p;
    tick(1, 0, 0, 0, 8'h00);
    checks++; if (need_new_line !== 1'b0) begin errors++; $display("FAIL reset_nnl got=%b exp=0", need_new_line); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (line_count !== 12'd0) begin errors++; $display("FAIL reset_line_count got=%0d exp=0", line_count); end
    checks++; if (level_done !== 1'b0 || game_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b%b exp=00", level_done, game_done); end
    p = 0;
    for (int c = 0; c < 24; c++) begin
      tick(0, (c % 8) == 0, 0, 0, 8'h30);
      if (need_new_line === 1'b1) p++;
    end
    checks++; if (p != 0 || level !== 3'd0) begin errors++; $display("FAIL idle_quiet got pulses=%0d level=%0d exp 0/0", p, level); end
  endtask

  task automatic test_speed_one;
    int p, bad;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 8'h00);
    p = 0; bad = 0;
    for (int f = 0; f < 5; f++)
      for (int c = 0; c < 8; c++) begin
        tick(0, c == 0, 0, 0, 8'h10);
        if (need_new_line === 1'b1) begin p++; if (c != 1) bad++; end
      end
    checks++; if (p != 5 || bad != 0) begin errors++; $display("FAIL speed_one_pulses got=%0d late=%0d exp=5/0", p, bad); end
    checks++; if (line_count !== 12'd5) begin errors++; $display("FAIL speed_one_count got=%0d exp=5", line_count); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL speed_one_level got=%0d exp=1", level); end
  endtask

  task automatic test_half_speed;
    logic [6:0] mask;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 8'h00);
    mask = '0;
    for (int f = 0; f < 7; f++)
      for (int c = 0; c < 8; c++) begin
        tick(0, c == 0, 0, 0, 8'h08);
        if (need_new_line === 1'b1 && c == 1) mask[f] = 1'b1;
      end
    checks++; if (mask !== 7'b0101010) begin errors++; $display("FAIL half_speed_frames got=%b exp=0101010", mask); end
    checks++; if (line_count !== 12'd3) begin errors++; $display("FAIL half_speed_count got=%0d exp=3", line_count); end
    checks++; if (dut.acc_q !== 4'd8) begin errors++; $display("FAIL half_speed_acc got=%0d exp=8", dut.acc_q); end
  endtask

  task automatic test_burst;
    int offs[$];
    int exp_offs[4] = '{1, 5, 9, 13};
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      tick(0, c == 0, 0, 0, 8'h40);
      if (need_new_line === 1'b1) offs.push_back(c);
    end
    checks++;
    if (offs.size() != 4) begin errors++; $display("FAIL burst_count got=%0d exp=4", offs.size()); end
    else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (offs[i] != exp_offs[i]) begin errors++; $display("FAIL burst_offset%0d got=%0d exp=%0d", i, offs[i], exp_offs[i]); end
      end
  endtask

  task automatic test_pause;
    int p;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h30);
    p = 0;
    for (int f = 0; f < 10; f++)
      for (int c = 0; c < 8; c++) begin
        tick(0, c == 0, 0, 1, 8'h30);
        if (need_new_line === 1'b1) p++;
      end
    checks++; if (p != 0 || line_count !== 12'd0) begin errors++; $display("FAIL pause_frozen got pulses=%0d count=%0d exp 0/0", p, line_count); end
    for (int c = 0; c < 20; c++) begin
      tick(0, 0, 0, 0, 8'h30);
      if (need_new_line === 1'b1) p++;
    end
    checks++; if (p != 3 || line_count !== 12'd3) begin errors++; $display("FAIL pause_resume got pulses=%0d count=%0d exp 3/3", p, line_count); end
  endtask

  task automatic test_levels;
    int pulses, dones, extra, k;
    bit sg;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 8'h00);
    pulses = 0; dones = 0; extra = 0; k = 0;
    while (level !== 3'd2 && k < 400) begin
`ifdef ROAD_SCROLL_LEVEL_WAIT_EN
      sg = (dones > 0);
`else
      sg = 1'b0;
`endif
      tick(0, (k % 8) == 0, sg, 0, 8'h30);
      if (need_new_line === 1'b1) begin if (dones > 0) extra++; else pulses++; end
      if (level_done === 1'b1) begin
        dones++;
        checks++; if (line_count !== 12'd8) begin errors++; $display("FAIL level_done_count got=%0d exp=8", line_count); end
      end
      k++;
    end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL level_advance got=%0d exp=2 (timeout)", level); end
    checks++; if (pulses != 8 || dones != 1 || extra != 0) begin errors++; $display("FAIL level1_pulses got=%0d done=%0d extra=%0d exp 8/1/0", pulses, dones, extra); end
    checks++; if (line_count !== 12'd0) begin errors++; $display("FAIL level2_count_clear got=%0d exp=0", line_count); end
    pulses = 0; k = 0;
    while (game_done !== 1'b1 && k < 400) begin
      tick(0, (k % 8) == 0, 0, 0, 8'h30);
      if (need_new_line === 1'b1) pulses++;
      k++;
    end
    checks++; if (game_done !== 1'b1 || pulses != 8 || level !== 3'd2) begin errors++; $display("FAIL game_done got gd=%b pulses=%0d level=%0d exp 1/8/2", game_done, pulses, level); end
    extra = 0;
    for (int c = 0; c < 24; c++) begin
      tick(0, (c % 8) == 0, 0, 0, 8'h30);
      if (need_new_line === 1'b1) extra++;
    end
    checks++; if (extra != 0 || game_done !== 1'b1 || level !== 3'd2) begin errors++; $display("FAIL game_done_hold got extra=%0d gd=%b level=%0d exp 0/1/2", extra, game_done, level); end
  endtask

  task automatic test_reset_mid;
    int p;
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h60);
    tick(0, 0, 0, 0, 8'h60);
    checks++; if (need_new_line !== 1'b1) begin errors++; $display("FAIL mid_first_pulse got=%b exp=1", need_new_line); end
    tick(0, 0, 0, 0, 8'h60);
    tick(1, 0, 0, 0, 8'h60);
    checks++;
    if (level !== 3'd0 || line_count !== 12'd0 || need_new_line !== 1'b0 || level_done !== 1'b0 || game_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got level=%0d count=%0d nnl=%b ld=%b gd=%b exp all 0", level, line_count, need_new_line, level_done, game_done);
    end
    p = 0;
    for (int c = 0; c < 32; c++) begin
      tick(0, (c % 8) == 0, 0, 0, 8'h30);
      if (need_new_line === 1'b1) p++;
    end
    checks++; if (p != 0 || level !== 3'd0) begin errors++; $display("FAIL mid_reset_idle got pulses=%0d level=%0d exp 0/0", p, level); end
  endtask

  task automatic test_random;
    bit r, sof, sg, pz;
    logic [7:0] spd;
    pz = 0;
    tick(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom % 400) == 0;
      sg  = ($urandom % 25) == 0;
      sof = ($urandom % 6) == 0;
      if (($urandom % 10) == 0) pz = ~pz;
      spd = (($urandom % 15) == 0) ? 8'hFF : 8'($urandom % 96);
      tick(r, sof, sg, pz, spd);
      checks++; if (need_new_line !== m_nnl) begin errors++; $display("FAIL rnd_nnl t=%0d got=%b exp=%b", m_t, need_new_line, m_nnl); end
      checks++; if (level !== 3'(m_level)) begin errors++; $display("FAIL rnd_level t=%0d got=%0d exp=%0d", m_t, level, m_level); end
      checks++; if (line_count !== 12'(m_cnt)) begin errors++; $display("FAIL rnd_count t=%0d got=%0d exp=%0d", m_t, line_count, m_cnt); end
      checks++; if (level_done !== m_ld) begin errors++; $display("FAIL rnd_level_done t=%0d got=%b exp=%b", m_t, level_done, m_ld); end
      checks++; if (game_done !== (m_stage == 3)) begin errors++; $display("FAIL rnd_game_done t=%0d got=%b exp=%b", m_t, game_done, m_stage == 3); end
    end
  endtask

  initial begin
    test_reset();
    test_speed_one();
    test_half_speed();
    test_burst();
    test_pause();
    test_levels();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
